layer_param_loader: RTL and testbench

- Writer side of the `layer` parameter interface. It accepts a masked word stream of biases and weights, with each word carried as two XOR shares.
- Each word is unmasked into a shadow buffer. On a well-formed load, the whole buffer is committed atomically to the flat weight/bias buses that drive one `layer` instance.
- The layer never sees a half-loaded parameter set.

---
 rtl/layer_pkg.sv | 33 +++
 rtl/param_shadow_buf.sv | 33 +++
 rtl/layer_param_loader.sv | 153 +++++++++++++++
 tb/tb_layer_param_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared definitions for the layer parameter interface: loader FSM states and
// flat-bus index helpers used by both the loader and the layer.
`timescale 1ns/1ps
package layer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        LOAD_W = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Words in one full parameter stream: all biases followed by all weights.
    function automatic int unsigned n_words(input int unsigned in_size,
                                            input int unsigned out_size);
        return out_size * (in_size + 1);
    endfunction

    // LSB position of bias j on the flat bias bus.
    function automatic int unsigned bias_lsb(input int unsigned j,
                                             input int unsigned width);
        return j * width;
    endfunction

    // LSB position of weight (row r, column c) on the flat weight bus.
    function automatic int unsigned weight_lsb(input int unsigned r,
                                               input int unsigned c,
                                               input int unsigned in_size,
                                               input int unsigned width);
        return (r * in_size + c) * width;
    endfunction

endpackage

// File: rtl/param_shadow_buf.sv
// Shadow register array for one parameter set: single write port and a
// parallel read-out of every entry for the atomic commit copy.
`timescale 1ns/1ps
module param_shadow_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 55,
    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     we,
    output logic [DEPTH*WIDTH-1:0]   rd_flat
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_rd
        assign rd_flat[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule

// File: rtl/layer_param_loader.sv
// Writer side of the layer parameter interface: unmasks a two-share word
// stream into a shadow buffer and commits it atomically on a well-framed load.
`timescale 1ns/1ps
module layer_param_loader
    import layer_pkg::*;
#(
    parameter int unsigned INPUT_SIZE  = 10,
    parameter int unsigned OUTPUT_SIZE = 5,
    parameter int unsigned WIDTH       = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic [WIDTH-1:0]                    in_mask,
    input  logic                                in_last,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [OUTPUT_SIZE*WIDTH-1:0]        b_flat,
    output logic [OUTPUT_SIZE*INPUT_SIZE*WIDTH-1:0] w_flat,
    output logic                                params_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int unsigned N_WORDS = n_words(INPUT_SIZE, OUTPUT_SIZE);
    localparam int unsigned N_W     = OUTPUT_SIZE * INPUT_SIZE;
    localparam int unsigned IDX_W   = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int unsigned ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int unsigned BW      = OUTPUT_SIZE * WIDTH;
    localparam int unsigned WW      = N_W * WIDTH;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic                      xfer;
    logic [ADDR_W-1:0]         wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic [N_WORDS*WIDTH-1:0]  shadow_flat;
    logic [BW-1:0]             commit_b;
    logic [WW-1:0]             commit_w;

    assign xfer    = in_valid && in_ready;
    assign wr_data = in_data ^ in_mask;

    // Biases occupy shadow entries 0..OUTPUT_SIZE-1, weights follow row-major.
    always_comb begin
        wr_addr = ADDR_W'(idx);
        if (state == LOAD_W) begin
            wr_addr = ADDR_W'(idx) + ADDR_W'(OUTPUT_SIZE);
        end
    end

    param_shadow_buf #(
        .WIDTH (WIDTH),
        .DEPTH (N_WORDS)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .we      (xfer),
        .rd_flat (shadow_flat)
    );

    // Map shadow entries onto the flat buses the layer consumes.
    for (genvar j = 0; j < int'(OUTPUT_SIZE); j++) begin : g_bias
        assign commit_b[bias_lsb(j, WIDTH) +: WIDTH] = shadow_flat[j*WIDTH +: WIDTH];
    end

    for (genvar r = 0; r < int'(OUTPUT_SIZE); r++) begin : g_row
        for (genvar c = 0; c < int'(INPUT_SIZE); c++) begin : g_col
            assign commit_w[weight_lsb(r, c, INPUT_SIZE, WIDTH) +: WIDTH] =
                shadow_flat[(OUTPUT_SIZE + r*INPUT_SIZE + c)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            params_valid <= 1'b0;
            b_flat       <= '0;
            w_flat       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD_B;
                        idx      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (in_last) begin
                            state    <= IDLE;
                            idx      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else if (idx == IDX_W'(OUTPUT_SIZE - 1)) begin
                            state <= LOAD_W;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOAD_W: begin
                    if (xfer) begin
                        // in_last must appear exactly on the final weight.
                        if ((idx == IDX_W'(N_W - 1)) && in_last) begin
                            state    <= COMMIT;
                            in_ready <= 1'b0;
                        end else if ((idx == IDX_W'(N_W - 1)) || in_last) begin
                            state    <= IDLE;
                            idx      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    b_flat       <= commit_b;
                    w_flat       <= commit_w;
                    params_valid <= 1'b1;
                    done         <= 1'b1;
                    state        <= IDLE;
                    idx          <= '0;
                    busy         <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    idx      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_param_loader.sv
// Scoreboard bench for layer_param_loader at INPUT_SIZE=2, OUTPUT_SIZE=2, WIDTH=16.
`timescale 1ns/1ps
module tb_layer_param_loader;

    localparam int unsigned IS = 2;
    localparam int unsigned OS = 2;
    localparam int unsigned W  = 16;
    localparam int unsigned BW = OS * W;
    localparam int unsigned WW = OS * IS * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  in_mask = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] b_flat;
    logic [WW-1:0] w_flat;
    logic          params_valid;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic          is_err;
        logic [BW-1:0] b;
        logic [WW-1:0] w;
        logic          pv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    layer_param_loader #(
        .INPUT_SIZE  (IS),
        .OUTPUT_SIZE (OS),
        .WIDTH       (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_mask      (in_mask),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .b_flat       (b_flat),
        .w_flat       (w_flat),
        .params_valid (params_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done/err pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got done=%0b err=%0b expected no event", done, err);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 64'({done, err}), mon_e.is_err ? 64'h1 : 64'h2);
                check("commit_b_flat", 64'(b_flat), 64'(mon_e.b));
                check("commit_w_flat", 64'(w_flat), 64'(mon_e.w));
                check("commit_params_valid", 64'(params_valid), 64'(mon_e.pv));
            end
        end
    end

    task automatic push_exp(input logic is_err, input logic [BW-1:0] b,
                            input logic [WW-1:0] w, input logic pv);
        exp_t e;
        e.is_err = is_err;
        e.b      = b;
        e.w      = w;
        e.pv     = pv;
        exp_q.push_back(e);
    endtask

    // Start pulse; optionally presents a junk word in the same cycle, which must not transfer.
    task automatic do_start(input logic junk);
        @(negedge clk);
        start    = 1'b1;
        in_valid = junk;
        in_data  = 16'hDEAD;
        in_mask  = 16'h0000;
        in_last  = junk;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [W-1:0] plain, input logic [W-1:0] mask,
                             input logic last, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = W'($urandom);
            in_mask  = W'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = plain ^ mask;
        in_mask  = mask;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends words base+first .. base+first+count-1; last_at marks in_last (-1: never).
    task automatic send_stream(input logic [W-1:0] base, input int first, input int count,
                               input int last_at, input bit gaps, input bit rmask,
                               input int mid_start_at);
        logic [W-1:0] mask;
        for (int k = first; k < first + count; k++) begin
            if (k == mid_start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            mask = rmask ? W'($urandom) : 16'hA5A5;
            send_word(base + W'(k), mask, k == last_at, gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_b_flat", 64'(b_flat), 64'h0);
        check("reset_w_flat", 64'(w_flat), 64'h0);
        check("reset_params_valid", 64'(params_valid), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done_err", 64'({done, err}), 64'h0);

        // Load 1: words 1..6, fixed mask, junk word alongside start.
        push_exp(1'b0, 32'h0002_0001, 64'h0006_0005_0004_0003, 1'b1);
        do_start(1'b1);
        check("load_in_ready", 64'(in_ready), 64'h1);
        check("load_busy", 64'(busy), 64'h1);
        send_stream(16'h0001, 0, 6, 5, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'h0);

        // Load 2: same words with gaps and random masks.
        push_exp(1'b0, 32'h0002_0001, 64'h0006_0005_0004_0003, 1'b1);
        do_start(1'b0);
        send_stream(16'h0001, 0, 6, 5, 1'b1, 1'b1, -1);
        repeat (3) @(negedge clk);

        // in_last on word 3 (first weight).
        push_exp(1'b1, 32'h0002_0001, 64'h0006_0005_0004_0003, 1'b1);
        do_start(1'b0);
        send_stream(16'h0040, 0, 3, 2, 1'b0, 1'b1, -1);
        repeat (2) @(negedge clk);
        check("err_idle_busy", 64'(busy), 64'h0);
        check("err_idle_in_ready", 64'(in_ready), 64'h0);

        // in_last on the first bias word.
        push_exp(1'b1, 32'h0002_0001, 64'h0006_0005_0004_0003, 1'b1);
        do_start(1'b0);
        send_stream(16'h0050, 0, 1, 0, 1'b0, 1'b1, -1);
        repeat (2) @(negedge clk);

        // Final word without in_last.
        push_exp(1'b1, 32'h0002_0001, 64'h0006_0005_0004_0003, 1'b1);
        do_start(1'b0);
        send_stream(16'h0060, 0, 6, -1, 1'b1, 1'b1, -1);
        repeat (2) @(negedge clk);

        // Reload 0x10..0x15 with a start mid-load; old set held until commit.
        push_exp(1'b0, 32'h0011_0010, 64'h0015_0014_0013_0012, 1'b1);
        do_start(1'b0);
        send_stream(16'h0010, 0, 3, 5, 1'b0, 1'b1, 2);
        check("reload_mid_b_flat", 64'(b_flat), 64'h0000_0000_0002_0001);
        check("reload_mid_params_valid", 64'(params_valid), 64'h1);
        send_stream(16'h0010, 3, 3, 5, 1'b0, 1'b1, -1);
        check("reload_commit_cycle_w_flat", 64'(w_flat), 64'h0006_0005_0004_0003);
        check("reload_commit_cycle_done", 64'(done), 64'h0);
        @(negedge clk);
        @(negedge clk);
        check("done_low_after_pulse", 64'(done), 64'h0);
        repeat (2) @(negedge clk);

        // Reset after word 4 clears everything asynchronously.
        do_start(1'b0);
        send_stream(16'h0030, 0, 4, 5, 1'b0, 1'b1, -1);
        rst = 1'b1;
        #1;
        check("midreset_b_flat", 64'(b_flat), 64'h0);
        check("midreset_w_flat", 64'(w_flat), 64'h0);
        check("midreset_params_valid", 64'(params_valid), 64'h0);
        check("midreset_busy_ready", 64'({busy, in_ready}), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fresh load after reset.
        push_exp(1'b0, 32'h0022_0021, 64'h0026_0025_0024_0023, 1'b1);
        do_start(1'b0);
        send_stream(16'h0021, 0, 6, 5, 1'b1, 1'b1, -1);
        repeat (5) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
